piano_player: RTL and testbench

// - Score sequencer driving the 8 key lines (t0..t7) of the piano synthesiser: the key-press side of that interface.
// - Reads chord/duration entries from a score ROM; holds each chord mask for its duration, then a silent articulation gap.
// - Supports start, stop, pause and looped playback; its chord output feeds the piano's key inputs bit-for-bit (bit i -> ti).

---
 rtl/piano_pkg.sv | 21 ++
 rtl/score_rom.sv | 22 ++
 rtl/piano_player.sv | 159 +++++++++++++++
 tb/tb_piano_player.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// rtl/piano_pkg.sv - shared state encoding and score entry layout for piano_player
package piano_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_PLAY,
        S_GAP,
        S_DONE
    } state_e;

    localparam int ENTRY_W  = 16;
    localparam int MASK_LSB = 0;
    localparam int MASK_W   = 8;
    localparam int DUR_LSB  = 8;
    localparam int DUR_W    = 4;

    localparam logic [DUR_W-1:0] END_DUR = '0;

endpackage

// File: rtl/score_rom.sv
// rtl/score_rom.sv - synchronous score ROM, one-cycle read latency
module score_rom
    import piano_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter logic [ENTRY_W*(2**ADDR_W)-1:0] SCORE_INIT = '0
) (
    input  logic               clk_i,
    input  logic [ADDR_W-1:0]  addr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] rdata_q;

    // Entry i occupies SCORE_INIT[i*ENTRY_W +: ENTRY_W]
    always_ff @(posedge clk_i) begin
        rdata_q <= SCORE_INIT[int'(addr_i)*ENTRY_W +: ENTRY_W];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/piano_player.sv
// rtl/piano_player.sv - score sequencer driving the eight piano key lines
module piano_player
    import piano_pkg::*;
#(
    parameter int BEAT_TICKS = 12_000_000,
    parameter int GAP_TICKS  = 600_000,
    parameter int ADDR_W     = 6,
    parameter logic [ENTRY_W*(2**ADDR_W)-1:0] SCORE_INIT = '0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              pause_i,
    input  logic              loop_en_i,
    output logic [7:0]        chord_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [ADDR_W-1:0] step_o
);

    localparam int TICK_W = (BEAT_TICKS > 1) ? $clog2(BEAT_TICKS) : 1;
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(BEAT_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [ADDR_W-1:0] STEP_LAST = '1;

    state_e              state_q, state_d;
    logic [MASK_W-1:0]   chord_q, chord_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [ADDR_W-1:0]   step_q, step_d;
    logic [DUR_W-1:0]    beat_q, beat_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [GAP_W-1:0]    gap_q, gap_d;

    logic [ENTRY_W-1:0]  rom_data;
    logic [MASK_W-1:0]   entry_mask;
    logic [DUR_W-1:0]    entry_dur;
    logic                unused_rsvd;

    score_rom #(
        .ADDR_W     (ADDR_W),
        .SCORE_INIT (SCORE_INIT)
    ) u_rom (
        .clk_i   (clk_i),
        .addr_i  (step_q),
        .rdata_o (rom_data)
    );

    assign entry_mask  = rom_data[MASK_LSB +: MASK_W];
    assign entry_dur   = rom_data[DUR_LSB +: DUR_W];
    assign unused_rsvd = ^rom_data[ENTRY_W-1:DUR_LSB+DUR_W];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            chord_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            step_q  <= '0;
            beat_q  <= '0;
            tick_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            chord_q <= chord_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            step_q  <= step_d;
            beat_q  <= beat_d;
            tick_q  <= tick_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        chord_d = chord_q;
        step_d  = step_q;
        beat_d  = beat_q;
        tick_d  = tick_q;
        gap_d   = gap_q;

        unique case (state_q)
            S_IDLE: begin
                chord_d = '0;
                if (start_i) begin
                    state_d = S_FETCH;
                    step_d  = '0;
                end
            end
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                if (entry_dur != END_DUR) begin
                    state_d = S_PLAY;
                    chord_d = entry_mask;
                    beat_d  = entry_dur;
                    tick_d  = '0;
                end else if (loop_en_i) begin
                    state_d = S_FETCH;
                    step_d  = '0;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_PLAY: begin
                if (!pause_i) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (beat_q == DUR_W'(1)) begin
                            state_d = S_GAP;
                            chord_d = '0;
                            gap_d   = '0;
                        end else begin
                            beat_d = beat_q - DUR_W'(1);
                        end
                    end else begin
                        tick_d = tick_q + TICK_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (!pause_i) begin
                    if (gap_q == GAP_LAST) begin
                        // Stepping past the last address wraps to 0 and counts as END
                        step_d  = step_q + ADDR_W'(1);
                        state_d = (step_q == STEP_LAST && !loop_en_i) ? S_DONE : S_FETCH;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            S_DONE: begin
                chord_d = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                chord_d = '0;
            end
        endcase

        if (stop_i) begin
            state_d = S_IDLE;
            chord_d = '0;
        end

        busy_d = (state_d == S_FETCH) || (state_d == S_DECODE) ||
                 (state_d == S_PLAY)  || (state_d == S_GAP);
        done_d = (state_d == S_DONE);
    end

    assign chord_o = chord_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign step_o  = step_q;

endmodule

// File: tb/tb_piano_player.sv
// tb/tb_piano_player.sv - directed vector bench for piano_player
module tb_piano_player;

    localparam int ADDR_W = 3;
    localparam logic [127:0] SCORE_A = 128'h0000_0000_0000_0000_0000_0000_0105_0201;
    localparam logic [127:0] SCORE_B = 128'h0180_0140_0120_0110_0108_0104_0102_0101;

    typedef struct {
        int         lo;
        int         hi;
        logic       start;
        logic       stop;
        logic       pause;
        logic       loop_en;
        logic       chk;
        logic [7:0] chord;
        logic       busy;
        logic       done;
    } seg_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, pause = 1'b0, loop_en = 1'b0;
    logic [7:0] chord_a, chord_b;
    logic busy_a, busy_b, done_a, done_b;
    logic [ADDR_W-1:0] step_a, step_b;

    int n_checks = 0;
    int n_fail = 0;
    seg_t segs[$];

    always #5 clk = ~clk;

    piano_player #(.BEAT_TICKS(4), .GAP_TICKS(1), .ADDR_W(ADDR_W), .SCORE_INIT(SCORE_A)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .pause_i(pause),
        .loop_en_i(loop_en), .chord_o(chord_a), .busy_o(busy_a), .done_o(done_a), .step_o(step_a)
    );

    piano_player #(.BEAT_TICKS(4), .GAP_TICKS(1), .ADDR_W(ADDR_W), .SCORE_INIT(SCORE_B)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .pause_i(pause),
        .loop_en_i(loop_en), .chord_o(chord_b), .busy_o(busy_b), .done_o(done_b), .step_o(step_b)
    );

    task automatic check(input string name, input int cyc, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, want 0x%0h", name, cyc, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_chord", -1, 32'(chord_a), 32'h0);
        check("rst_busy", -1, 32'(busy_a), 32'h0);
        check("rst_done", -1, 32'(done_a), 32'h0);
        check("rst_step", -1, 32'(step_a), 32'h0);
        rst_n = 1'b1;
    endtask

    task automatic add(input int lo, input int hi, input logic st, input logic sp, input logic pa,
                       input logic lp, input logic ck, input logic [7:0] ch, input logic bz, input logic dn);
        seg_t s;
        s.lo = lo; s.hi = hi; s.start = st; s.stop = sp; s.pause = pa; s.loop_en = lp;
        s.chk = ck; s.chord = ch; s.busy = bz; s.done = dn;
        segs.push_back(s);
    endtask

    initial begin
        // basic score, no loop
        add(0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0);
        add(1, 2, 0, 0, 0, 0, 1, 8'h00, 1, 0);
        add(3, 10, 0, 0, 0, 0, 1, 8'h01, 1, 0);
        add(11, 13, 0, 0, 0, 0, 1, 8'h00, 1, 0);
        add(14, 17, 0, 0, 0, 0, 1, 8'h05, 1, 0);
        add(18, 20, 0, 0, 0, 0, 1, 8'h00, 1, 0);
        add(21, 21, 0, 0, 0, 0, 1, 8'h00, 0, 1);
        add(22, 24, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        // looped playback, stopped at cycle 30
        add(0, 0, 1, 0, 0, 1, 1, 8'h00, 0, 0);
        add(1, 2, 0, 0, 0, 1, 1, 8'h00, 1, 0);
        add(3, 10, 0, 0, 0, 1, 1, 8'h01, 1, 0);
        add(11, 13, 0, 0, 0, 1, 1, 8'h00, 1, 0);
        add(14, 17, 0, 0, 0, 1, 1, 8'h05, 1, 0);
        add(18, 22, 0, 0, 0, 1, 1, 8'h00, 1, 0);
        add(23, 23, 0, 0, 0, 1, 0, 8'h00, 1, 0);
        add(24, 29, 0, 0, 0, 1, 1, 8'h01, 1, 0);
        add(30, 30, 0, 1, 0, 1, 1, 8'h01, 1, 0);
        add(31, 33, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        // pause during the first note
        add(0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0);
        add(1, 2, 0, 0, 0, 0, 1, 8'h00, 1, 0);
        add(3, 4, 0, 0, 0, 0, 1, 8'h01, 1, 0);
        add(5, 9, 0, 0, 1, 0, 1, 8'h01, 1, 0);
        add(10, 15, 0, 0, 0, 0, 1, 8'h01, 1, 0);
        add(16, 18, 0, 0, 0, 0, 1, 8'h00, 1, 0);
        add(19, 22, 0, 0, 0, 0, 1, 8'h05, 1, 0);
        add(23, 25, 0, 0, 0, 0, 1, 8'h00, 1, 0);
        add(26, 26, 0, 0, 0, 0, 1, 8'h00, 0, 1);
        add(27, 28, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        // stop and start together, then restart
        add(0, 0, 1, 0, 0, 0, 1, 8'h00, 0, 0);
        add(1, 2, 0, 0, 0, 0, 1, 8'h00, 1, 0);
        add(3, 5, 0, 0, 0, 0, 1, 8'h01, 1, 0);
        add(6, 6, 1, 1, 0, 0, 1, 8'h01, 1, 0);
        add(7, 7, 0, 0, 0, 0, 1, 8'h00, 0, 0);
        add(8, 8, 1, 0, 0, 0, 1, 8'h00, 0, 0);
        add(9, 10, 0, 0, 0, 0, 1, 8'h00, 1, 0);
        add(11, 13, 0, 0, 0, 0, 1, 8'h01, 1, 0);

        foreach (segs[i]) begin
            if (segs[i].lo == 0) do_reset();
            for (int c = segs[i].lo; c <= segs[i].hi; c++) begin
                @(posedge clk);
                #1;
                start = segs[i].start; stop = segs[i].stop;
                pause = segs[i].pause; loop_en = segs[i].loop_en;
                if (segs[i].chk) begin
                    check($sformatf("seg%0d_chord", i), c, 32'(chord_a), 32'(segs[i].chord));
                    check($sformatf("seg%0d_busy", i), c, 32'(busy_a), 32'(segs[i].busy));
                    check($sformatf("seg%0d_done", i), c, 32'(done_a), 32'(segs[i].done));
                end
            end
        end

        // full ROM without END marker: address wrap ends the score
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0);
            for (int k = 0; k < 8; k++) begin
                if (c == 3 + 7 * k) begin
                    check("rom_chord", c, 32'(chord_b), 32'(1 << k));
                    check("rom_step", c, 32'(step_b), 32'(k));
                end
            end
            check("rom_done", c, 32'(done_b), 32'(c == 57));
            if (c == 55) check("rom_last_chord", c, 32'(chord_b), 32'h80);
            if (c == 57) check("rom_wrap_step", c, 32'(step_b), 32'h0);
            if (c == 58) check("rom_idle_busy", c, 32'(busy_b), 32'h0);
        end

        // reset asserted mid-note
        do_reset();
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0);
        end
        check("mid_chord_pre", 5, 32'(chord_a), 32'h01);
        #2 rst_n = 1'b0;
        #1;
        check("mid_chord_async", 5, 32'(chord_a), 32'h0);
        check("mid_busy_async", 5, 32'(busy_a), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            check("post_rst_chord", c, 32'(chord_a), 32'h0);
            check("post_rst_busy", c, 32'(busy_a), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
